// File: rtl/pop_count_window_stats.sv
// rtl/pop_count_window_stats.sv - windowed sum/min/max/count statistics over popcount results
//
// Accepts one 6-bit popcount result per in_valid/in_ready transfer and emits one
// record per window of WINDOW words, or earlier when flush closes a non-empty window.
// Optional macro: POP_STATS_MINMAX_EN builds min/max tracking; without it out_min
// and out_max are tied to 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_cnt carries the popcount value
//   flush                 close the current window early (ignored if empty or in HOLD)
//   out_valid/out_ready   output record handshake, record held until accepted
//   out_sum               saturating sum of the window
//   out_min/out_max       minimum/maximum in_cnt of the window
//   out_words             number of words in the window (1..WINDOW)

module pop_count_window_stats #(
    parameter int  WINDOW = 16,
    parameter int  SUM_W  = 10,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_cnt,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [5:0]       out_min,
    output logic [5:0]       out_max,
    output logic [CNT_W-1:0] out_words
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};
    localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WINDOW);

    state_t           state, state_nxt;
    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W-1:0] sum_add;
    logic [CNT_W-1:0] cnt_add;
    logic             accept;
    logic             close;
    logic             clear;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // One extra bit catches the carry out, which is the saturation condition.
    assign sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(in_cnt);
    assign sum_add = sum_ext[SUM_W] ? SUM_MAX : sum_ext[SUM_W-1:0];
    assign cnt_add = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        close     = 1'b0;
        clear     = 1'b0;
        case (state)
            ACCUM: begin
                // A same-cycle accept counts towards a non-empty window for flush.
                if ((accept && (cnt_add == WIN_C)) || (flush && (accept || (cnt_q != '0)))) begin
                    close     = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    clear     = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cnt_q     <= '0;
            out_sum   <= '0;
            out_words <= '0;
        end else begin
            if (clear) begin
                sum_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                sum_q <= sum_add;
                cnt_q <= cnt_add;
            end
            if (close) begin
                out_sum   <= accept ? sum_add : sum_q;
                out_words <= accept ? cnt_add : cnt_q;
            end
        end
    end

`ifdef POP_STATS_MINMAX_EN
    logic [5:0] min_q, max_q;
    logic [5:0] min_add, max_add;

    assign min_add = (in_cnt < min_q) ? in_cnt : min_q;
    assign max_add = (in_cnt > max_q) ? in_cnt : max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q   <= 6'd63;
            max_q   <= 6'd0;
            out_min <= 6'd0;
            out_max <= 6'd0;
        end else begin
            if (clear) begin
                min_q <= 6'd63;
                max_q <= 6'd0;
            end else if (accept) begin
                min_q <= min_add;
                max_q <= max_add;
            end
            if (close) begin
                out_min <= accept ? min_add : min_q;
                out_max <= accept ? max_add : max_q;
            end
        end
    end
`else
    assign out_min = 6'd0;
    assign out_max = 6'd0;
`endif

endmodule

// File: tb/tb_pop_count_window_stats.sv
// tb/tb_pop_count_window_stats.sv - self-checking bench for pop_count_window_stats

module tb_pop_count_window_stats;

    localparam int WINDOW = 4;
    localparam int SUM_W  = 6;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_cnt;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [5:0]       out_min;
    logic [5:0]       out_max;
    logic [CNT_W-1:0] out_words;

    pop_count_window_stats #(
        .WINDOW(WINDOW),
        .SUM_W (SUM_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_cnt   (in_cnt),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_min  (out_min),
        .out_max  (out_max),
        .out_words(out_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flush_mode: 0 none, 1 flush with last word, 2 flush pulse one cycle after last word
    typedef struct {
        int               n;
        logic [3:0][5:0]  w;
        int               flush_mode;
        logic [SUM_W-1:0] sum;
        logic [5:0]       mn;
        logic [5:0]       mx;
        logic [CNT_W-1:0] words;
    } vec_t;

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic [5:0]       mn;
        logic [5:0]       mx;
        logic [CNT_W-1:0] words;
    } rec_t;

    rec_t exp_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(int n, int w0, int w1, int w2, int w3, int fm,
                                int s, int mn, int mx, int wd);
        vec_t v;
        v.n          = n;
        v.w[0]       = 6'(w0);
        v.w[1]       = 6'(w1);
        v.w[2]       = 6'(w2);
        v.w[3]       = 6'(w3);
        v.flush_mode = fm;
        v.sum        = SUM_W'(s);
        v.mn         = 6'(mn);
        v.mx         = 6'(mx);
        v.words      = CNT_W'(wd);
        return v;
    endfunction

    function automatic logic [5:0] mm(input logic [5:0] v);
`ifdef POP_STATS_MINMAX_EN
        return v;
`else
        return 6'd0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int s, input int mn, input int mx, input int wd);
        rec_t r;
        r.sum   = SUM_W'(s);
        r.mn    = mm(6'(mn));
        r.mx    = mm(6'(mx));
        r.words = CNT_W'(wd);
        exp_q.push_back(r);
    endtask

    task automatic send_word(input logic [5:0] c, input logic fl);
        int g;
        g = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_cnt   = c;
        flush    = fl;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("in_ready_wait", int'(g < 20), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_flush();
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Expects out_valid at the first negedge after the closing edge (1-cycle latency).
    task automatic take_record(input string name);
        rec_t e;
        int   g;
        g = 0;
        @(negedge clk);
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({name, "_latency"}, g, 0);
        if (exp_q.size() == 0) begin
            check({name, "_queue_nonempty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({name, "_sum"},   int'(out_sum),   int'(e.sum));
            check({name, "_min"},   int'(out_min),   int'(e.mn));
            check({name, "_max"},   int'(out_max),   int'(e.mx));
            check({name, "_words"}, int'(out_words), int'(e.words));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid_drop"}, int'(out_valid), 0);
        check({name, "_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(4, 1, 2, 3, 4, 0, 10, 1, 4, 4);
        vecs[1] = mk(4, 5, 5, 5, 5, 0, 20, 5, 5, 4);
        vecs[2] = mk(2, 7, 3, 0, 0, 2, 10, 3, 7, 2);
        vecs[3] = mk(1, 9, 0, 0, 0, 1, 9, 9, 9, 1);
        vecs[4] = mk(4, 32, 32, 32, 32, 0, 63, 32, 32, 4);
        vecs[5] = mk(4, 1, 1, 1, 2, 1, 5, 1, 2, 4);
        vecs[6] = mk(4, 40, 0, 63, 10, 0, 63, 0, 63, 4);
        vecs[7] = mk(3, 10, 20, 30, 0, 1, 60, 10, 30, 3);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cnt    = 6'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_sum",   int'(out_sum),   0);
        check("rst_out_min",   int'(out_min),   0);
        check("rst_out_max",   int'(out_max),   0);
        check("rst_out_words", int'(out_words), 0);
        rst_n = 1'b1;

        // Backpressure: record held stable, in_valid and flush ignored during HOLD.
        push_exp(10, 1, 4, 4);
        for (int i = 1; i <= 4; i++) send_word(6'(i), 1'b0);
        in_valid = 1'b1;
        in_cnt   = 6'd50;
        flush    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready",  int'(in_ready),  0);
            check("bp_sum",       int'(out_sum),   10);
            check("bp_words",     int'(out_words), 4);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        take_record("bp");

        for (int k = 0; k < 8; k++) begin
            push_exp(int'(vecs[k].sum), int'(vecs[k].mn), int'(vecs[k].mx), int'(vecs[k].words));
            for (int i = 0; i < vecs[k].n; i++)
                send_word(vecs[k].w[i], (vecs[k].flush_mode == 1) && (i == vecs[k].n - 1));
            if (vecs[k].flush_mode == 2) send_flush();
            take_record($sformatf("vec%0d", k));
        end

        // Flush with an empty window produces nothing.
        send_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_flush_valid", int'(out_valid), 0);
            check("empty_flush_ready", int'(in_ready), 1);
        end

        // Reset mid-window discards the partial window.
        send_word(6'd5, 1'b0);
        send_word(6'd6, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready",  int'(in_ready),  1);
        check("midrst_out_sum",   int'(out_sum),   0);
        check("midrst_out_words", int'(out_words), 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(4, 1, 1, 4);
        for (int i = 0; i < 4; i++) send_word(6'd1, 1'b0);
        take_record("post_rst");

        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pop_count_window_stats.md
Name: pop_count_window_stats

Overview:
- Downstream consumer of the 32-bit population-count stage. Accepts one 6-bit popcount result (0..32) per valid/ready transfer.
- Accumulates results over a window of WINDOW words, then emits one record per window: sum, minimum, maximum and word count.
- Feeds the statistics/readout side of the popcount datapath. Uses the same single `clk` domain as the popcount stage.

Parameters:
- WINDOW, 16, number of accepted words per full window; legal range is 1 or more.
- SUM_W, 10, width of out_sum; legal range is 6 or more; the sum saturates at 2^SUM_W-1.
- CNT_W, $clog2(WINDOW+1), width of the word counter and out_words; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_cnt carries a popcount result.
- in_ready  output  1  block can accept in_cnt this cycle.
- in_cnt  input  6  popcount value; values 33..63 are accepted and processed as-is.
- flush  input  1  single-cycle request to close the current window early.
- out_valid  output  1  result record valid; held until accepted.
- out_ready  input  1  consumer accepts the record.
- out_sum  output  SUM_W  saturating sum of in_cnt over the window.
- out_min  output  6  minimum in_cnt in the window.
- out_max  output  6  maximum in_cnt in the window.
- out_words  output  CNT_W  number of words accumulated in the window (1..WINDOW).

Behaviour:
- Reset (asynchronous assert on rst_n low, synchronous release):
  - state=ACCUM, in_ready=1, out_valid=0.
  - out_sum, out_min, out_max and out_words are all 0.
  - Internal accumulators: sum=0, min=63, max=0, word count=0.
- Accept condition: a word is accepted when in_valid && in_ready.
- State ACCUM (in_ready=1, out_valid=0). On each accept:
  - sum <= sat(sum+in_cnt), where sat clamps to 2^SUM_W-1.
  - min <= the smaller of min and in_cnt.
  - max <= the larger of max and in_cnt.
  - word count <= word count+1.
- Window close. The window closes when either:
  - an accept brings the word count to WINDOW, or
  - flush=1 with at least one word in the window, counting a word accepted in the same cycle.
- On close:
  - The final values, including any same-cycle word, are registered into the out_* ports.
  - Go to HOLD. out_valid rises on the next clock edge.
  - Latency is 1 cycle from the last accepted word to out_valid.
- State HOLD (in_ready=0, out_valid=1).
  - out_* are stable until out_valid && out_ready.
  - On that handshake: clear the accumulators to their reset values, return to ACCUM, set in_ready=1 and out_valid=0 on the next cycle.
  - No bubble-free pass-through: at least one cycle separates a window's last accept from the next window's first accept.
- Flush cases:
  - flush with an empty window and no same-cycle accept: ignored, no record emitted.
  - flush in HOLD: ignored.
  - flush together with the WINDOW-th accept: a single close, out_words=WINDOW.
- Saturation: once sum reaches 2^SUM_W-1 it stays there for the rest of the window. min, max and word count continue updating normally.
- out_valid and the out_* ports are driven only from registers; there is no combinational path from inputs to outputs.
- in_ready depends only on state, never on out_ready.
- Reset mid-operation: any partial window or pending record is discarded, and all registers return to their reset values.

Optional Feature:
- Macro: POP_STATS_MINMAX_EN.
- Defined: min/max tracking is implemented as described above.
- Undefined: no min/max registers or comparators are built, and out_min and out_max are tied to 0. Sum, count, handshake and timing are unchanged.

Test Plan:
- Full window (WINDOW=4, SUM_W=10): accept 1,2,3,4 back-to-back -> one cycle later out_valid=1 with sum=10, min=1, max=4, words=4.
- Backpressure (WINDOW=4): same stimulus with out_ready=0 for 5 cycles -> out_* stable, in_ready=0 for the whole hold. Then raise out_ready -> next cycle in_ready=1, and the next window 5,5,5,5 gives sum=20, min=5, max=5.
- Early flush (WINDOW=4): accept 7 then 3, then pulse flush -> sum=10, min=3, max=7, words=2.
- Flush with accept / empty flush: flush alone when the window is empty -> no out_valid. Accept 9 together with flush -> record sum=9, min=9, max=9, words=1.
- Saturation (WINDOW=4, SUM_W=6): accept 32,32,32,32 -> sum=63, min=32, max=32, words=4.
- Reset mid-window: accept 2 words, assert rst_n=0 for one cycle -> out_valid=0 and in_ready=1. A following full window of 1,1,1,1 gives sum=4, words=4, with no residue from before the reset.
